// File: rtl/rvv_xrf_wb_queue_if.sv
// Retire-lane to scalar write-back bus: NUM_IN result lanes in, one result out,
// plus occupancy status.
interface rvv_xrf_wb_queue_if #(
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*ADDR_W-1:0] in_addr;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [ADDR_W-1:0]        out_addr;
    logic [DATA_W-1:0]        out_data;
    logic                     out_ready;
    logic [CNT_W-1:0]         count;
    logic                     idle;

    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data, count, idle
    );

    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data, count, idle
    );
endinterface

// File: rtl/rvv_xrf_wb_queue.sv
// Multi-lane scalar write-back buffer: compacts up to NUM_IN retire results per
// cycle (x0 dropped) into a circular flop FIFO and drains one per cycle.
module rvv_xrf_wb_queue #(
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    rvv_xrf_wb_queue_if.slave     bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  free;
    logic [CNT_W-1:0]  n_enq;
    logic [NUM_IN-1:0] ready;
    logic [NUM_IN-1:0] wr_en;
    logic [PTR_W-1:0]  wr_idx [NUM_IN];
    logic              head_valid;
    logic              deq;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    // Ready is a prefix mask on registered free space; enqueued lanes are packed
    // into consecutive slots so that skipped/x0 lanes leave no holes.
    always_comb begin
        free       = CNT_W'(DEPTH) - count_q;
        n_enq      = '0;
        ready      = '0;
        wr_en      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            wr_idx[i] = wr_ptr_q + PTR_W'(n_enq);
            ready[i]  = !rst && (free >= CNT_W'(i + 1));
            if (bus.in_valid[i] && ready[i] &&
                (bus.in_addr[i*ADDR_W +: ADDR_W] != '0)) begin
                wr_en[i] = 1'b1;
                n_enq    = n_enq + CNT_W'(1);
            end
        end
        head_valid = !rst && (count_q != '0);
        deq        = head_valid && bus.out_ready;
        count_d    = count_q + n_enq - CNT_W'(deq);
        wr_ptr_d   = wr_ptr_q + PTR_W'(n_enq);
        rd_ptr_d   = rd_ptr_q + PTR_W'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_en[i]) begin
                addr_mem_q[wr_idx[i]] <= bus.in_addr[i*ADDR_W +: ADDR_W];
                data_mem_q[wr_idx[i]] <= bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CNT_W'(DEPTH));
            assert (n_enq <= free);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = head_valid;
    assign bus.out_addr  = head_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign bus.out_data  = head_valid ? data_mem_q[rd_ptr_q] : '0;
    assign bus.count     = count_q;
    assign bus.idle      = (count_q == '0) && (bus.in_valid == '0);

endmodule
